mem_stage_lsu: RTL and testbench
================================

Name: mem_stage_lsu

Overview:
Parametrised MEM-stage load/store unit for the five-stage MIPS pipeline. It sits between the EX/MEM and MEM/WB registers. It generates aligned data-memory requests with byte enables over a req/ack handshake to variable-latency memory, and stalls the pipeline while a request is outstanding. Loads are extracted, sign- or zero-extended and registered into MEM/WB; misaligned accesses and bus timeouts raise exception pulses.

Parameters:
ADDR_W, 32, effective-address width.
DATA_W, 32, data-bus width; legal values 32 or 64.
TIMEOUT_CYC, 64, maximum cycles waiting for mem_ack before a bus error; 0 disables the timeout.

Ports:
clk  in  1  pipeline clock.
rst  in  1  reset, asynchronous, active-low.
ex_valid  in  1  EX/MEM holds a valid instruction.
aluresult  in  ADDR_W  effective address, or ALU result for non-memory ops.
memread  in  1  load.
memwrite  in  1  store.
memsize  in  2  access size: 00 byte, 01 half, 10 word, 11 dword (dword legal only when DATA_W=64).
memunsigned  in  1  zero-extend the load when 1, sign-extend when 0.
swdata  in  DATA_W  store data, right-justified.
stall  out  1  freezes PC, IF/ID, ID/EX and EX/MEM.
mem_req  out  1  memory request.
mem_we  out  1  write request.
mem_addr  out  ADDR_W  address aligned to DATA_W/8 bytes.
mem_be  out  DATA_W/8  byte enables.
mem_wdata  out  DATA_W  lane-replicated store data.
mem_ack  in  1  memory completion; read data is valid in the same cycle.
mem_rdata  in  DATA_W  read data.
wb_valid  out  1  MEM/WB holds a valid instruction.
wb_data  out  DATA_W  load result, or zero-extended aluresult for non-memory ops.
misalign  out  1  one-cycle exception pulse for a misaligned or illegal-size access.
buserr  out  1  one-cycle exception pulse on timeout.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, timeout counter 0, and every output 0 (mem_req, mem_we, mem_addr, mem_be, mem_wdata, wb_valid, wb_data, misalign, buserr). Asserting reset during WAIT drops mem_req immediately; the access is discarded.
- memop = ex_valid & (memread | memwrite). If memread and memwrite are both 1, the access is a store.
- lane = aluresult[log2(DATA_W/8)-1:0].
- Misaligned when: size half and lane[0]≠0; size word and lane[1:0]≠0; size dword and lane[2:0]≠0; or memsize=11 with DATA_W=32.
- Non-memory op: wb_valid/wb_data register ex_valid/aluresult at the next edge (1-cycle latency). stall=0.
- FSM IDLE:
  - memop with a misaligned access: no request. Next edge: misalign=1, wb_valid=0. stall=0.
  - memop with an aligned access: stall=1 combinationally. Next edge: go to WAIT with mem_req=1, mem_we=memwrite, mem_addr=aluresult with low lane bits cleared, mem_be=(size mask)<<lane, mem_wdata=swdata low bytes replicated across all lanes.
- FSM WAIT:
  - mem_addr, mem_be, mem_wdata and mem_we are held stable.
  - stall = !mem_ack.
  - On mem_ack: next edge mem_req=0, state IDLE, wb_valid=1. For a load, wb_data = (mem_rdata >> lane*8) masked to size, then extended per memunsigned. For a store, wb_data=0.
  - Timeout counter increments each WAIT cycle without ack. When it reaches TIMEOUT_CYC (nonzero): stall=0 that cycle; next edge mem_req=0, buserr=1, wb_valid=0, state IDLE.
  - mem_ack on the same cycle the counter reaches TIMEOUT_CYC: the ack wins.
- Load-use latency: at least 2 cycles from the EX/MEM capture. Back-to-back memory ops are accepted in the cycle after ack, so each access needs at least 2 cycles.
- misalign and buserr are high for exactly one cycle.
- mem_ack outside WAIT is ignored.

Decomposition:
- Package lsu_pkg holds: size encodings (SZ_B, SZ_H, SZ_W, SZ_D), FSM state enum, and functions size_mask(size) and is_misaligned(addr, size).
- Sub-module lsu_load_align performs the combinational shift, mask and sign/zero-extend of read data, instantiated once.

Test Plan:
- Word load: aluresult=0x100, memsize=10, memrdata=0xDEADBEEF, ack after 3 cycles -> mem_be=1111, stall high 3 cycles, wb_data=0xDEADBEEF, wb_valid=1.
- Signed byte load: address 0x103, rdata=0x80FFFFFF -> mem_addr=0x100, mem_be=1000, wb_data=0xFFFFFF80; same access with memunsigned=1 -> wb_data=0x00000080.
- Half store: address 0x202, swdata=0x1234 -> mem_we=1, mem_be=1100, mem_wdata=0x12341234, wb_valid=1, wb_data=0.
- Misaligned word load at 0x101 -> no mem_req, misalign pulses 1 cycle, stall never asserted, wb_valid=0.
- Timeout with TIMEOUT_CYC=4 and no ack -> mem_req high 4 cycles, then buserr=1 for one cycle, wb_valid=0, FSM IDLE.
- rst pulled low mid-WAIT -> mem_req and stall drop immediately; after release a new load completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the MEM-stage load/store unit.
package lsu_pkg;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;
   localparam logic [1:0] SZ_D = 2'b11;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } lsu_state_t;

   // Byte mask of an access, right-justified (before shifting to its lane).
   function automatic logic [7:0] size_mask(input logic [1:0] size);
      case (size)
         SZ_B:    return 8'h01;
         SZ_H:    return 8'h03;
         SZ_W:    return 8'h0f;
         default: return 8'hff;
      endcase
   endfunction

   // Natural-alignment check on the low address bits.
   function automatic logic is_misaligned(input logic [2:0] addr, input logic [1:0] size);
      case (size)
         SZ_H:    return addr[0];
         SZ_W:    return |addr[1:0];
         SZ_D:    return |addr;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Read-data alignment: shift the addressed lane down, mask to size, extend.
module lsu_load_align
   import lsu_pkg::*;
#(
   parameter  int DATA_W = 32,
   localparam int LW     = $clog2(DATA_W/8)
) (
   input  logic [DATA_W-1:0] rdata,
   input  logic [LW-1:0]     lane,
   input  logic [1:0]        size,
   input  logic              zext,
   output logic [DATA_W-1:0] data
);

   logic [DATA_W-1:0] sh;

   assign sh = rdata >> {lane, 3'b000};

   // Size casts of signed slices give sign extension, plain slices zero extension.
   always_comb begin
      data = sh;
      case (size)
         SZ_B: data = zext ? DATA_W'(sh[7:0])  : DATA_W'($signed(sh[7:0]));
         SZ_H: data = zext ? DATA_W'(sh[15:0]) : DATA_W'($signed(sh[15:0]));
         SZ_W: data = zext ? DATA_W'(sh[31:0]) : DATA_W'($signed(sh[31:0]));
         default: data = sh;
      endcase
   end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: request generation, wait/stall, load writeback.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   ST_IDLE | no access outstanding; non-memory ops pass straight to MEM/WB
//   ST_WAIT | request on the bus, waiting for mem_ack or the timeout
module mem_stage_lsu
   import lsu_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ex_valid,
   input  logic [ADDR_W-1:0]   aluresult,
   input  logic                memread,
   input  logic                memwrite,
   input  logic [1:0]          memsize,
   input  logic                memunsigned,
   input  logic [DATA_W-1:0]   swdata,
   output logic                stall,
   output logic                mem_req,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W/8-1:0] mem_be,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic                mem_ack,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic                wb_valid,
   output logic [DATA_W-1:0]   wb_data,
   output logic                misalign,
   output logic                buserr
);

   localparam int NB = DATA_W/8;
   localparam int LW = $clog2(NB);
   localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC+1) : 1;
   // Last waiting cycle index; the timeout fires on the TIMEOUT_CYC-th cycle without ack.
   localparam logic [CW-1:0] TC_LAST = CW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC-1 : 0);

   lsu_state_t        state, state_nxt;
   logic [CW-1:0]     tmo_cnt;
   logic              memop, bad_access, tmo_hit;
   logic [LW-1:0]     lane, lane_q;
   logic [1:0]        size_q;
   logic              zext_q, load_q;
   logic [2:0]        rep_m1;
   logic [NB-1:0]     be_nxt;
   logic [DATA_W-1:0] wdata_nxt, load_data;

   assign memop      = ex_valid & (memread | memwrite);
   assign lane       = aluresult[LW-1:0];
   assign bad_access = is_misaligned(aluresult[2:0], memsize) | ((memsize == SZ_D) && (DATA_W < 64));
   assign tmo_hit    = (TIMEOUT_CYC != 0) && (state == ST_WAIT) && !mem_ack && (tmo_cnt == TC_LAST);
   assign be_nxt     = NB'(size_mask(memsize)) << lane;

   // Replicate the right-justified store data across every lane of the bus.
   always_comb begin
      wdata_nxt = '0;
      case (memsize)
         SZ_B:    rep_m1 = 3'd0;
         SZ_H:    rep_m1 = 3'd1;
         SZ_W:    rep_m1 = 3'd3;
         default: rep_m1 = 3'd7;
      endcase
      for (int i = 0; i < NB; i++) begin
         wdata_nxt[8*i +: 8] = swdata[8*(i & int'(rep_m1)) +: 8];
      end
   end

   lsu_load_align #(.DATA_W(DATA_W)) u_align (
      .rdata (mem_rdata),
      .lane  (lane_q),
      .size  (size_q),
      .zext  (zext_q),
      .data  (load_data)
   );

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_nxt;
   end

   // Next state and pipeline stall; stall is forced low while reset is held.
   always_comb begin
      state_nxt = state;
      stall     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (memop && !bad_access) begin
               stall     = 1'b1;
               state_nxt = ST_WAIT;
            end
         end
         ST_WAIT: begin
            stall = !mem_ack && !tmo_hit;
            if (mem_ack || tmo_hit) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
      if (!rst) stall = 1'b0;
   end

   // Bus request, captured access attributes, timeout counter and MEM/WB outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_be    <= '0;
         mem_wdata <= '0;
         wb_valid  <= 1'b0;
         wb_data   <= '0;
         misalign  <= 1'b0;
         buserr    <= 1'b0;
         tmo_cnt   <= '0;
         lane_q    <= '0;
         size_q    <= SZ_B;
         zext_q    <= 1'b0;
         load_q    <= 1'b0;
      end else begin
         misalign <= 1'b0;
         buserr   <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (memop) begin
                  wb_valid <= 1'b0;
                  wb_data  <= '0;
                  if (bad_access) begin
                     misalign <= 1'b1;
                  end else begin
                     mem_req   <= 1'b1;
                     mem_we    <= memwrite;
                     mem_addr  <= {aluresult[ADDR_W-1:LW], LW'(0)};
                     mem_be    <= be_nxt;
                     mem_wdata <= wdata_nxt;
                     lane_q    <= lane;
                     size_q    <= memsize;
                     zext_q    <= memunsigned;
                     load_q    <= !memwrite;
                     tmo_cnt   <= '0;
                  end
               end else begin
                  wb_valid <= ex_valid;
                  wb_data  <= DATA_W'(aluresult);
               end
            end
            ST_WAIT: begin
               wb_valid <= 1'b0;
               if (mem_ack) begin
                  mem_req  <= 1'b0;
                  wb_valid <= 1'b1;
                  wb_data  <= load_q ? load_data : '0;
                  tmo_cnt  <= '0;
               end else if (tmo_hit) begin
                  mem_req <= 1'b0;
                  buserr  <= 1'b1;
                  tmo_cnt <= '0;
               end else if (TIMEOUT_CYC != 0) begin
                  tmo_cnt <= tmo_cnt + CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Randomised bench for mem_stage_lsu against a byte-level reference model.
module tb_mem_stage_lsu;

   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int TMO = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          ex_valid, memread, memwrite, memunsigned, mem_ack;
   logic [AW-1:0] aluresult;
   logic [1:0]    memsize;
   logic [DW-1:0] swdata, mem_rdata;
   logic          stall, mem_req, mem_we, wb_valid, misalign, buserr;
   logic [AW-1:0] mem_addr;
   logic [3:0]    mem_be;
   logic [DW-1:0] mem_wdata, wb_data;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mem_stage_lsu #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TMO)) dut (
      .clk(clk), .rst(rst), .ex_valid(ex_valid), .aluresult(aluresult),
      .memread(memread), .memwrite(memwrite), .memsize(memsize),
      .memunsigned(memunsigned), .swdata(swdata), .stall(stall),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .wb_valid(wb_valid), .wb_data(wb_data), .misalign(misalign), .buserr(buserr)
   );

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int nbytes(input logic [1:0] sz);
      return 1 << sz;
   endfunction

   function automatic bit model_bad(input logic [31:0] addr, input logic [1:0] sz);
      if (sz == 2'd3) return 1'b1;
      return (addr % nbytes(sz)) != 0;
   endfunction

   function automatic logic [3:0] model_be(input logic [31:0] addr, input logic [1:0] sz);
      int m;
      m = ((1 << nbytes(sz)) - 1) << (addr % 4);
      return m[3:0];
   endfunction

   function automatic logic [31:0] model_wdata(input logic [31:0] sw, input logic [1:0] sz);
      logic [31:0] w;
      for (int i = 0; i < 4; i++) w[8*i +: 8] = sw[8*(i % nbytes(sz)) +: 8];
      return w;
   endfunction

   function automatic logic [31:0] model_load(input logic [31:0] rdata, input logic [31:0] addr,
                                              input logic [1:0] sz, input bit uns);
      logic [63:0] v, mask;
      int bits;
      bits = 8 * nbytes(sz);
      v    = 64'(rdata) >> (8 * (addr % 4));
      mask = (64'd1 << bits) - 64'd1;
      v    = v & mask;
      if (!uns && v[bits-1]) v = v | ~mask;
      return v[31:0];
   endfunction

   // Non-memory op (or an invalid slot); optional stray mem_ack must be ignored.
   task automatic run_alu(input bit vld, input logic [31:0] val, input bit noise);
      ex_valid  = vld;
      aluresult = val;
      memread   = vld ? 1'b0 : 1'($urandom);
      memwrite  = 1'b0;
      memsize   = 2'($urandom);
      mem_ack   = noise;
      mem_rdata = $urandom;
      @(negedge clk);
      check_val("alu_stall", stall, 0);
      @(posedge clk); #1;
      mem_ack = 1'b0;
      check_val("alu_wb_valid", wb_valid, vld);
      check_val("alu_wb_data", wb_data, val);
      check_val("alu_no_req", mem_req, 0);
   endtask

   // One memory access from IDLE; ack arrives after ack_dly waiting cycles.
   task automatic run_mem(input logic [31:0] addr, input bit rd, input bit wr, input logic [1:0] sz,
                          input bit uns, input logic [31:0] sw, input logic [31:0] rdata, input int ack_dly);
      bit bad, to;
      int exp_wait, req_cycles, stall_cycles;
      bad = model_bad(addr, sz);
      ex_valid = 1'b1; aluresult = addr; memread = rd; memwrite = wr;
      memsize = sz; memunsigned = uns; swdata = sw; mem_ack = 1'b0;
      @(negedge clk);
      check_val("issue_stall", stall, !bad);
      @(posedge clk); #1;
      if (bad) begin
         check_val("misalign", misalign, 1);
         check_val("mis_no_req", mem_req, 0);
         check_val("mis_wb_valid", wb_valid, 0);
         ex_valid = 1'b0; memread = 1'b0; memwrite = 1'b0;
         @(negedge clk);
         check_val("mis_stall", stall, 0);
         @(posedge clk); #1;
         check_val("misalign_pulse", misalign, 0);
         return;
      end
      check_val("req", mem_req, 1);
      check_val("we", mem_we, wr);
      check_val("addr", mem_addr, addr & 32'hffff_fffc);
      check_val("be", mem_be, model_be(addr, sz));
      check_val("wdata", mem_wdata, model_wdata(sw, sz));
      check_val("wait_wb_valid", wb_valid, 0);
      to           = (ack_dly >= TMO);
      exp_wait     = to ? TMO : ack_dly + 1;
      req_cycles   = 0;
      stall_cycles = 1;
      for (int c = 1; c <= TMO + 3; c++) begin
         mem_ack   = (c == ack_dly + 1);
         mem_rdata = (c == ack_dly + 1) ? rdata : $urandom;
         @(negedge clk);
         if (mem_req) begin
            req_cycles++;
            check_val("be_hold", mem_be, model_be(addr, sz));
         end
         if (stall) stall_cycles++;
         @(posedge clk); #1;
         mem_ack = 1'b0;
         if (!mem_req) break;
      end
      check_val("req_cycles", req_cycles, exp_wait);
      check_val("stall_cycles", stall_cycles, to ? TMO : ack_dly + 1);
      check_val("done_wb_valid", wb_valid, !to);
      check_val("buserr", buserr, to);
      if (!to) check_val("wb_data", wb_data, (rd && !wr) ? model_load(rdata, addr, sz, uns) : 32'h0);
      ex_valid = 1'b0; memread = 1'b0; memwrite = 1'b0;
      @(posedge clk); #1;
      check_val("buserr_pulse", buserr, 0);
      check_val("idle_wb_valid", wb_valid, 0);
   endtask

   initial begin
      ex_valid = 0; aluresult = '0; memread = 0; memwrite = 0; memsize = '0;
      memunsigned = 0; swdata = '0; mem_ack = 0; mem_rdata = '0;
      #3;
      check_val("rst_req", mem_req, 0);
      check_val("rst_we", mem_we, 0);
      check_val("rst_addr", mem_addr, 0);
      check_val("rst_be", mem_be, 0);
      check_val("rst_wdata", mem_wdata, 0);
      check_val("rst_wb_valid", wb_valid, 0);
      check_val("rst_wb_data", wb_data, 0);
      check_val("rst_misalign", misalign, 0);
      check_val("rst_buserr", buserr, 0);
      check_val("rst_stall", stall, 0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;

      run_alu(1'b1, 32'h1234_5678, 1'b0);
      run_alu(1'b0, 32'h0000_abcd, 1'b1);
      run_mem(32'h100, 1, 0, 2'd2, 0, 32'h0, 32'hdead_beef, 2);
      run_mem(32'h103, 1, 0, 2'd0, 0, 32'h0, 32'h80ff_ffff, 1);
      run_mem(32'h103, 1, 0, 2'd0, 1, 32'h0, 32'h80ff_ffff, 1);
      run_mem(32'h202, 0, 1, 2'd1, 0, 32'h1234, 32'h0, 0);
      run_mem(32'h101, 1, 0, 2'd2, 0, 32'h0, 32'h0, 0);
      run_mem(32'h100, 1, 0, 2'd3, 0, 32'h0, 32'h0, 0);
      run_mem(32'h300, 1, 0, 2'd2, 0, 32'h0, 32'h0, 100);
      run_mem(32'h302, 1, 0, 2'd1, 0, 32'h0, 32'h8001_7fff, TMO - 1);
      run_mem(32'h401, 1, 1, 2'd0, 0, 32'h5a, 32'hffff_ffff, 1);

      // Reset in the middle of a wait: request and stall must drop at once.
      ex_valid = 1'b1; aluresult = 32'h500; memread = 1'b1; memwrite = 1'b0; memsize = 2'd2;
      @(posedge clk); #1;
      check_val("pre_rst_req", mem_req, 1);
      @(negedge clk); #2;
      rst = 1'b0;
      #1;
      check_val("mid_rst_req", mem_req, 0);
      check_val("mid_rst_stall", stall, 0);
      check_val("mid_rst_be", mem_be, 0);
      @(posedge clk); #1;
      ex_valid = 1'b0; memread = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      run_mem(32'h504, 1, 0, 2'd2, 0, 32'h0, 32'hcafe_f00d, 1);

      for (int k = 0; k < 300; k++) begin
         if ($urandom_range(0, 3) == 0) begin
            run_alu(1'($urandom), $urandom, 1'($urandom));
         end else begin
            bit rd, wr;
            rd = 1'($urandom);
            wr = rd ? 1'($urandom) : 1'b1;
            run_mem($urandom, rd, wr, 2'($urandom), 1'($urandom), $urandom, $urandom,
                    $urandom_range(0, 5));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
